// File: rtl/sipo_lane_arbiter.sv
// Round-robin arbiter sharing one serial-to-parallel deserializer among NUM_REQ lanes;
// each completed word is presented with its source lane ID on a valid/ready port.
module sipo_lane_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int SHIFT_DIR = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         ser_in,
  input  logic [NUM_REQ-1:0]         ser_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       abort
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr, ptr_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [WIDTH-1:0] data_nx;
  logic [IDW-1:0]   id_nx;
  logic             valid_nx;
  logic             abort_nx;

  logic             found;
  logic [IDW-1:0]   pick;
  logic [IDW:0]     cand;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] word;

  // Search upward from the lane after the last grant, wrapping, so the last winner ranks lowest.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
  end

  assign pos  = (SHIFT_DIR != 0) ? CW'(WIDTH-1) - cnt : cnt;
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    grant_nx = grant;
    data_nx  = out_data;
    id_nx    = out_id;
    valid_nx = out_valid;
    abort_nx = 1'b0;
    word     = shreg;
    word[pos] = ser_in[ptr];
    case (state)
      IDLE: begin
        if (found) begin
          state_nx       = SHIFT;
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          ptr_nx         = pick;
          cnt_nx         = '0;
          shreg_nx       = '0;
        end
      end
      SHIFT: begin
        // A dropped request wins over a final-bit capture on the same edge.
        if (!req[ptr]) begin
          state_nx = IDLE;
          grant_nx = '0;
          cnt_nx   = '0;
          abort_nx = 1'b1;
        end else if (ser_valid[ptr]) begin
          if (cnt == CW'(WIDTH-1)) begin
            state_nx = HOLD;
            grant_nx = '0;
            cnt_nx   = '0;
            data_nx  = word;
            id_nx    = ptr;
            valid_nx = 1'b1;
          end else begin
            shreg_nx = word;
            cnt_nx   = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= IDW'(NUM_REQ-1);
      cnt       <= '0;
      shreg     <= '0;
      grant     <= '0;
      out_data  <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      grant     <= grant_nx;
      out_data  <= data_nx;
      out_id    <= id_nx;
      out_valid <= valid_nx;
      abort     <= abort_nx;
    end
  end
endmodule
